// File: rtl/packet_queue_write_arbiter.sv
// Round-robin arbiter and store-and-forward sequencer for the packet queue
// write port. One whole packet is collected from the granted source into a
// local buffer, then written to the queue as one unbroken write-enable burst.
//
// Ports:
//   clk, reset        queue write clock, synchronous active-high reset
//   i_src_valid       per-source word valid
//   i_src_last        per-source final word of packet
//   i_src_data        source s at [s*DATA_WIDTH +: DATA_WIDTH]
//   o_src_ready       per-source accept (combinational, granted source only)
//   o_q_write_en      queue write enable (combinational, !i_q_full in DRAIN)
//   o_q_data          queue write data
//   i_q_full          queue full flag
//   o_grant_id        currently granted source
//   o_busy            high while collecting or draining
//   o_truncated       one-cycle pulse on the last transfer of a truncated packet
//   o_split_error     sticky; a full queue interrupted a burst
module packet_queue_write_arbiter #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned NUM_SOURCES       = 4,
    parameter int unsigned MAX_PACKET_LENGTH = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SOURCES-1:0]            i_src_valid,
    input  logic [NUM_SOURCES-1:0]            i_src_last,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] i_src_data,
    output logic [NUM_SOURCES-1:0]            o_src_ready,
    output logic                              o_q_write_en,
    output logic [DATA_WIDTH-1:0]             o_q_data,
    input  logic                              i_q_full,
    output logic [$clog2(NUM_SOURCES)-1:0]    o_grant_id,
    output logic                              o_busy,
    output logic                              o_truncated,
    output logic                              o_split_error
);

    localparam int unsigned GW = $clog2(NUM_SOURCES);
    localparam int unsigned LW = $clog2(MAX_PACKET_LENGTH + 1);
    localparam int unsigned PW = $clog2(MAX_PACKET_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t                r_state;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last_grant;
    logic [LW-1:0]         r_len;
    logic [PW-1:0]         r_rd_ptr;
    logic                  r_drop;
    logic                  r_split_error;
    logic [DATA_WIDTH-1:0] r_buf [MAX_PACKET_LENGTH];

    logic [DATA_WIDTH-1:0] w_src_words [NUM_SOURCES];
    logic [DATA_WIDTH-1:0] w_word;
    logic [NUM_SOURCES-1:0] w_ready;
    logic                  w_xfer;
    logic                  w_last_xfer;
    logic                  w_room;
    logic                  w_write_en;
    logic                  w_at_end;
    logic                  w_found;
    logic [GW-1:0]         w_pick;
    int unsigned           w_idx;

    // Round-robin pick: first valid source after the last grant, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int unsigned k = 1; k <= NUM_SOURCES; k++) begin
            w_idx = (32'(r_last_grant) + k) % NUM_SOURCES;
            if (!w_found && i_src_valid[GW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end
        end
    end

    // Handshake and drain decode for the granted source.
    always_comb begin
        for (int s = 0; s < NUM_SOURCES; s++) begin
            w_src_words[s] = i_src_data[s*DATA_WIDTH +: DATA_WIDTH];
        end
        w_word  = w_src_words[r_grant];
        w_ready = '0;
        if (r_state == ST_COLLECT) begin
            w_ready[r_grant] = 1'b1;
        end
        w_xfer      = |(i_src_valid & w_ready);
        w_last_xfer = |(i_src_valid & i_src_last & w_ready);
        w_room      = (r_len < LW'(MAX_PACKET_LENGTH));
        w_write_en  = (r_state == ST_DRAIN) && !i_q_full;
        w_at_end    = (LW'(r_rd_ptr) == (r_len - LW'(1)));
    end

    assign o_src_ready   = w_ready;
    assign o_q_write_en  = w_write_en;
    assign o_q_data      = (r_state == ST_DRAIN) ? r_buf[r_rd_ptr] : '0;
    // Truncation includes a word being discarded on the last transfer itself.
    assign o_truncated   = w_last_xfer && (r_drop || !w_room);
    assign o_grant_id    = r_grant;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_split_error = r_split_error;

    // Packet buffer; contents need no reset since len gates every read.
    always_ff @(posedge clk) begin
        if ((r_state == ST_COLLECT) && w_xfer && w_room) begin
            r_buf[r_len[PW-1:0]] <= w_word;
        end
    end

    // Control state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_last_grant  <= GW'(NUM_SOURCES - 1);
            r_len         <= '0;
            r_rd_ptr      <= '0;
            r_drop        <= 1'b0;
            r_split_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_len        <= '0;
                        r_drop       <= 1'b0;
                        r_state      <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_xfer) begin
                        if (w_room) begin
                            r_len <= r_len + LW'(1);
                        end else begin
                            r_drop <= 1'b1;
                        end
                        if (w_last_xfer) begin
                            r_rd_ptr <= '0;
                            r_state  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_write_en) begin
                        if (w_at_end) begin
                            r_rd_ptr <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PW'(1);
                        end
                    end else if (r_rd_ptr != '0) begin
                        // Stall inside a burst: the queue will see a false boundary.
                        r_split_error <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_queue_write_arbiter.sv
// Self-checking bench for packet_queue_write_arbiter: directed scenarios with
// hand-computed expectations plus randomized traffic, all compared every cycle
// against a queue-based behavioural model of the arbiter.
module tb_packet_queue_write_arbiter;

    localparam int DW   = 8;
    localparam int NS   = 4;
    localparam int MAXL = 8;
    localparam int GW   = 2;
    localparam int SQD  = 1024;

    logic               clk = 1'b0;
    logic               reset;
    logic [NS-1:0]      src_valid, src_last, src_ready;
    logic [NS*DW-1:0]   src_data;
    logic               q_we, q_full;
    logic [DW-1:0]      q_data;
    logic [GW-1:0]      grant;
    logic               busy, trunc, split;

    always #5 clk = ~clk;

    packet_queue_write_arbiter #(
        .DATA_WIDTH(DW), .NUM_SOURCES(NS), .MAX_PACKET_LENGTH(MAXL)
    ) dut (
        .clk(clk), .reset(reset),
        .i_src_valid(src_valid), .i_src_last(src_last), .i_src_data(src_data),
        .o_src_ready(src_ready), .o_q_write_en(q_we), .o_q_data(q_data),
        .i_q_full(q_full), .o_grant_id(grant), .o_busy(busy),
        .o_truncated(trunc), .o_split_error(split)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Source traffic: per-source word queues with last flags
    logic [DW-1:0] sw [NS][SQD];
    bit            sl [NS][SQD];
    int            wn [NS];
    int            rn [NS];
    bit [NS-1:0]   gate = '1;
    int            gap_pct = 0;
    int            qf_pct = 0;
    bit            qf_val = 1'b0;

    task automatic add_pkt(input int s, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) begin
            if (wn[s] < SQD) begin
                sw[s][wn[s]] = base + DW'(k);
                sl[s][wn[s]] = (k == len - 1);
                wn[s]++;
            end
        end
    endtask

    function automatic bit src_empty();
        for (int s = 0; s < NS; s++) if (rn[s] != wn[s]) return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural model: transaction view with a collected-word queue
    int            m_mode;   // 0 idle, 1 collecting, 2 draining
    int            m_grant, m_last, m_rd;
    logic [DW-1:0] m_coll [$];
    bit            m_drop, m_split;

    task automatic model_reset();
        m_mode = 0; m_grant = 0; m_last = NS - 1; m_rd = 0;
        m_coll.delete(); m_drop = 0; m_split = 0;
    endtask

    task automatic model_update();
        bit f;
        case (m_mode)
            0: begin
                f = 0;
                for (int k = 1; k <= NS; k++) begin
                    int idx;
                    idx = (m_last + k) % NS;
                    if (!f && src_valid[idx]) begin
                        f = 1; m_grant = idx; m_last = idx;
                    end
                end
                if (f) begin m_mode = 1; m_coll.delete(); m_drop = 0; end
            end
            1: begin
                if (src_valid[m_grant]) begin
                    if (m_coll.size() < MAXL) m_coll.push_back(src_data[m_grant*DW +: DW]);
                    else m_drop = 1;
                    if (src_last[m_grant]) begin m_mode = 2; m_rd = 0; end
                end
            end
            default: begin
                if (!q_full) begin
                    m_rd++;
                    if (m_rd == m_coll.size()) begin m_mode = 0; m_rd = 0; end
                end else if (m_rd != 0) m_split = 1;
            end
        endcase
    endtask

    // Per-cycle comparison of every DUT output against the model
    task automatic compare();
        logic [NS-1:0] er;
        bit ewe, et;
        er = '0;
        if (m_mode == 1) er[m_grant] = 1'b1;
        ewe = (m_mode == 2) && !q_full;
        et  = (m_mode == 1) && src_valid[m_grant] && src_last[m_grant] &&
              (m_drop || m_coll.size() >= MAXL);
        chk("busy", busy, m_mode != 0);
        chk("grant_id", grant, m_grant);
        chk("src_ready", src_ready, er);
        chk("q_write_en", q_we, ewe);
        if (ewe) chk("q_data", q_data, m_coll[m_rd]);
        chk("truncated", trunc, et);
        chk("split_error", split, m_split);
    endtask

    // Observations and statistics for the directed scenarios
    logic          obs_we, obs_busy, obs_split, obs_trunc;
    logic [DW-1:0] obs_data;
    logic [GW-1:0] obs_grant;
    logic [NS-1:0] obs_ready;
    bit            prev_busy = 0;
    int            st_we, st_trunc, cur_run;
    int            st_hs [NS];
    int            st_runs [$];
    int            st_grants [$];

    task automatic clear_stats();
        st_we = 0; st_trunc = 0; cur_run = 0;
        st_runs.delete(); st_grants.delete();
        for (int s = 0; s < NS; s++) st_hs[s] = 0;
    endtask

    task automatic step(input bit rst);
        logic [NS-1:0] hs;
        @(negedge clk);
        reset = rst;
        for (int s = 0; s < NS; s++) begin
            bit v;
            v = gate[s] && (rn[s] < wn[s]) && (int'($urandom_range(99)) >= gap_pct);
            src_valid[s] = v;
            src_last[s]  = v && sl[s][rn[s]];
            src_data[s*DW +: DW] = v ? sw[s][rn[s]] : DW'($urandom);
        end
        q_full = (qf_pct > 0) ? (int'($urandom_range(99)) < qf_pct) : qf_val;
        #1;
        compare();
        obs_we = q_we; obs_data = q_data; obs_busy = busy; obs_split = split;
        obs_trunc = trunc; obs_grant = grant; obs_ready = src_ready;
        hs = src_valid & src_ready;
        if (obs_busy && !prev_busy) st_grants.push_back(int'(obs_grant));
        prev_busy = obs_busy;
        if (obs_we) begin st_we++; cur_run++; end
        else if (cur_run > 0) begin st_runs.push_back(cur_run); cur_run = 0; end
        if (obs_trunc) st_trunc++;
        if (rst) begin
            model_reset();
            for (int s = 0; s < NS; s++) begin rn[s] = 0; wn[s] = 0; end
        end else begin
            model_update();
            for (int s = 0; s < NS; s++) if (hs[s]) begin rn[s]++; st_hs[s]++; end
        end
    endtask

    task automatic run_idle(input int max);
        int i;
        i = 0;
        while (!(src_empty() && m_mode == 0) && i < max) begin step(0); i++; end
        if (i >= max) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: got %0d cycles expected idle within %0d", i, max);
        end
        step(0);
    endtask

    task automatic do_reset();
        step(1); step(1); clear_stats();
    endtask

    initial begin
        logic          wl [14];
        logic [DW-1:0] dl [14];
        logic [GW-1:0] gl [14];
        logic          bl [14];
        int            cnt, i;

        reset = 1'b1; src_valid = '0; src_last = '0; src_data = '0; q_full = 1'b0;
        for (int s = 0; s < NS; s++) begin wn[s] = 0; rn[s] = 0; end
        model_reset();
        clear_stats();

        // Reset state
        do_reset();
        step(0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_ready", obs_ready, 0);
        chk("rst_we", obs_we, 0);
        chk("rst_grant", obs_grant, 0);
        chk("rst_split", obs_split, 0);

        // Single 5-word packet from source 2, cycle-exact
        clear_stats();
        add_pkt(2, 5, 8'h11);
        for (int c = 0; c < 14; c++) begin
            step(0);
            wl[c] = obs_we; dl[c] = obs_data; gl[c] = obs_grant; bl[c] = obs_busy;
        end
        chk("t1_grant_c1", gl[1], 2);
        chk("t1_busy_c0", bl[0], 0);
        chk("t1_we_c5", wl[5], 0);
        for (int c = 6; c <= 10; c++) begin
            chk("t1_we_burst", wl[c], 1);
            chk("t1_data_burst", dl[c], 8'h11 + DW'(c - 6));
        end
        chk("t1_we_c11", wl[11], 0);
        chk("t1_busy_c11", bl[11], 0);
        chk("t1_trunc", st_trunc, 0);
        chk("t1_split", obs_split, 0);

        // Round-robin with all sources requesting
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < NS; s++) add_pkt(s, 2, DW'(8'h20 + 16 * r + 4 * s));
        run_idle(400);
        chk("t2_npkts", st_grants.size(), 12);
        for (int k = 0; k < st_grants.size() && k < 12; k++)
            chk("t2_grant_order", st_grants[k], k % NS);
        chk("t2_nbursts", st_runs.size(), 12);
        for (int k = 0; k < st_runs.size(); k++) chk("t2_burst_len", st_runs[k], 2);

        // Truncation: 11 words, 9 words (last one discarded), exactly MAXL words
        do_reset();
        add_pkt(0, 11, 8'h40);
        run_idle(200);
        chk("t3_acks", st_hs[0], 11);
        chk("t3_writes", st_we, MAXL);
        chk("t3_trunc", st_trunc, 1);
        clear_stats();
        add_pkt(0, 9, 8'h60);
        run_idle(200);
        chk("t3b_writes", st_we, MAXL);
        chk("t3b_trunc", st_trunc, 1);
        clear_stats();
        add_pkt(1, MAXL, 8'h80);
        run_idle(200);
        chk("t3c_writes", st_we, MAXL);
        chk("t3c_trunc", st_trunc, 0);

        // Valid gap of 3 cycles in a 6-word packet
        do_reset();
        add_pkt(1, 6, 8'h30);
        cnt = 0; i = 0;
        while (!(src_empty() && m_mode == 0) && i < 200) begin
            if (st_hs[1] == 3 && cnt < 3) begin gate[1] = 1'b0; cnt++; end
            else gate[1] = 1'b1;
            step(0); i++;
        end
        gate = '1;
        step(0);
        chk("t4_bursts", st_runs.size(), 1);
        if (st_runs.size() > 0) chk("t4_burst_len", st_runs[0], 6);

        // q_full before the first word: no split error, one burst afterwards
        do_reset();
        add_pkt(3, 4, 8'hA0);
        cnt = 0; i = 0;
        while (!(src_empty() && m_mode == 0) && i < 200) begin
            qf_val = (m_mode == 2) && (cnt < 4);
            if (qf_val) cnt++;
            step(0); i++;
        end
        qf_val = 1'b0;
        step(0);
        chk("t5_fullcycles", cnt, 4);
        chk("t5_bursts", st_runs.size(), 1);
        if (st_runs.size() > 0) chk("t5_burst_len", st_runs[0], 4);
        chk("t5_split", obs_split, 0);

        // q_full for one cycle mid-burst: split error, sticky until reset
        clear_stats();
        add_pkt(3, 4, 8'hB0);
        cnt = 0; i = 0;
        while (!(src_empty() && m_mode == 0) && i < 200) begin
            qf_val = (m_mode == 2) && (m_rd == 2) && (cnt == 0);
            if (qf_val) cnt++;
            step(0); i++;
        end
        qf_val = 1'b0;
        step(0);
        chk("t5b_bursts", st_runs.size(), 2);
        chk("t5b_split", obs_split, 1);
        add_pkt(0, 3, 8'hC0);
        run_idle(200);
        chk("t5b_split_sticky", obs_split, 1);
        do_reset();
        step(0);
        chk("t5b_split_cleared", obs_split, 0);

        // Reset mid-collect after 3 of 8 words, then priority restarts at 0
        do_reset();
        add_pkt(2, 8, 8'h50);
        i = 0;
        while (st_hs[2] < 3 && i < 100) begin step(0); i++; end
        chk("t6_acks_before_reset", st_hs[2], 3);
        step(1);
        step(0);
        chk("t6_busy", obs_busy, 0);
        chk("t6_ready", obs_ready, 0);
        chk("t6_we", obs_we, 0);
        clear_stats();
        add_pkt(3, 2, 8'h70);
        add_pkt(0, 2, 8'h78);
        run_idle(200);
        chk("t6_ngrants", st_grants.size(), 2);
        if (st_grants.size() > 0) chk("t6_first_grant", st_grants[0], 0);

        // Randomized traffic, first without back-pressure, then with it
        do_reset();
        for (int r = 0; r < 40; r++) begin
            gap_pct = (r < 15) ? 0 : 25;
            qf_pct  = (r < 20) ? 0 : 20;
            for (int s = 0; s < NS; s++)
                if ($urandom_range(2) != 0)
                    add_pkt(s, int'($urandom_range(12, 1)), DW'($urandom));
            run_idle(3000);
        end
        gap_pct = 0; qf_pct = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
